// File: rtl/console_tx_flush_scheduler.sv
// Decides when to close a console DMA packet by strobing the tlast marker write.
// Define CONSOLE_FLUSH_STATS_EN to add the packets/collision/timeout statistics counters.
module console_tx_flush_scheduler #(
    parameter int DATA_DEPTH     = 1000,
    parameter int HIGH_WATER     = 512,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        char_valid,
    input  logic [10:0] output_fifo_counter,
    input  logic        dma_armed,
    input  logic        force_flush,
    input  logic        marker_drained,
    output logic        receive_transfer_request,
    output logic        packet_open,
    output logic [10:0] unflushed_count,
`ifdef CONSOLE_FLUSH_STATS_EN
    output logic [31:0] packets_sent,
    output logic [31:0] collision_stalls,
    output logic [31:0] timeout_flushes,
`endif
    output logic [1:0]  state_dbg
);

    localparam int          TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [10:0] HW_L       = 11'(HIGH_WATER);
    localparam logic [10:0] FIFO_LIMIT = 11'(DATA_DEPTH - 1);
    localparam logic [10:0] CNT_MAX    = 11'h7FF;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ACCUM      = 2'd1,
        S_REQUEST    = 2'd2,
        S_WAIT_DRAIN = 2'd3
    } state_t;

    state_t        r_state;
    logic [10:0]   r_count;
    logic [TW-1:0] r_timer;
    logic          r_force;

    logic [10:0]   w_count_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic          w_force_nxt;
    logic          w_hw_hit;
    logic          w_to_hit;
    logic          w_qual;
    logic          w_flush;
    logic          w_strobe;

    // Flush decisions look at this cycle's updated count/timer so a flush never lags the triggering char.
    always_comb begin
        w_count_nxt = r_count;
        if (char_valid && (r_count != CNT_MAX))
            w_count_nxt = r_count + 11'd1;
        w_timer_nxt = r_timer;
        if (char_valid)
            w_timer_nxt = '0;
        else if (r_timer != TMAX)
            w_timer_nxt = r_timer + TW'(1);
    end

    assign w_force_nxt = r_force | force_flush;
    assign w_hw_hit    = (w_count_nxt >= HW_L);
    assign w_to_hit    = (w_timer_nxt == TMAX);
    assign w_qual      = enable & dma_armed & (output_fifo_counter < FIFO_LIMIT);
    assign w_flush     = (w_hw_hit | w_to_hit | w_force_nxt) & w_qual;
    assign w_strobe    = (r_state == S_REQUEST) & ~char_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_timer <= '0;
            r_force <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            case (r_state)
                S_IDLE: begin
                    if (char_valid) begin
                        r_state <= S_ACCUM;
                        r_timer <= '0;
                    end
                end
                S_ACCUM: begin
                    r_timer <= w_timer_nxt;
                    if (w_flush) begin
                        r_state <= S_REQUEST;
                        r_force <= 1'b0;
                    end else begin
                        r_force <= w_force_nxt;
                    end
                end
                S_REQUEST: begin
                    // A colliding char is counted into this packet; the marker goes out once the bus is free.
                    if (w_strobe) begin
                        r_state <= S_WAIT_DRAIN;
                        r_count <= '0;
                    end
                end
                S_WAIT_DRAIN: begin
                    if (marker_drained) begin
                        r_state <= (w_count_nxt != 11'd0) ? S_ACCUM : S_IDLE;
                        r_timer <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CONSOLE_FLUSH_STATS_EN
    logic [31:0] r_packets_sent;
    logic [31:0] r_collision_stalls;
    logic [31:0] r_timeout_flushes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_packets_sent     <= '0;
            r_collision_stalls <= '0;
            r_timeout_flushes  <= '0;
        end else begin
            if (w_strobe)
                r_packets_sent <= r_packets_sent + 32'd1;
            if ((r_state == S_REQUEST) && char_valid)
                r_collision_stalls <= r_collision_stalls + 32'd1;
            if ((r_state == S_ACCUM) && w_flush && w_to_hit)
                r_timeout_flushes <= r_timeout_flushes + 32'd1;
        end
    end

    assign packets_sent     = r_packets_sent;
    assign collision_stalls = r_collision_stalls;
    assign timeout_flushes  = r_timeout_flushes;
`endif

    assign receive_transfer_request = w_strobe;
    assign packet_open              = (r_count != 11'd0);
    assign unflushed_count          = r_count;
    assign state_dbg                = r_state;

endmodule

// File: tb/tb_console_tx_flush_scheduler.sv
// Bench for console_tx_flush_scheduler: vector table, directed corner sequences and a randomized run
// against a packet-level model.
module tb_console_tx_flush_scheduler;

    localparam int DD = 1000;
    localparam int HW = 4;
    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b1;
    logic        char_valid = 1'b0;
    logic [10:0] output_fifo_counter = 11'd0;
    logic        dma_armed = 1'b1;
    logic        force_flush = 1'b0;
    logic        marker_drained = 1'b0;
    logic        receive_transfer_request;
    logic        packet_open;
    logic [10:0] unflushed_count;
    logic [1:0]  state_dbg;
`ifdef CONSOLE_FLUSH_STATS_EN
    logic [31:0] packets_sent, collision_stalls, timeout_flushes;
`endif

    console_tx_flush_scheduler #(.DATA_DEPTH(DD), .HIGH_WATER(HW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .char_valid(char_valid),
        .output_fifo_counter(output_fifo_counter), .dma_armed(dma_armed),
        .force_flush(force_flush), .marker_drained(marker_drained),
        .receive_transfer_request(receive_transfer_request), .packet_open(packet_open),
        .unflushed_count(unflushed_count),
`ifdef CONSOLE_FLUSH_STATS_EN
        .packets_sent(packets_sent), .collision_stalls(collision_stalls),
        .timeout_flushes(timeout_flushes),
`endif
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Requested level inputs, applied at the next cycle boundary by tick().
    logic        req_en = 1'b1;
    logic        req_armed = 1'b1;
    logic [10:0] req_fifo = 11'd0;

    // Packet-level model: which phase the current packet is in and how many chars it holds.
    bit m_building, m_closing, m_in_flight, m_force;
    int m_chars, m_quiet;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_building = 0; m_closing = 0; m_in_flight = 0; m_force = 0;
        m_chars = 0; m_quiet = 0;
    endtask

    function automatic int model_state();
        if (m_closing) return 2;
        if (m_in_flight) return 3;
        if (m_building) return 1;
        return 0;
    endfunction

    task automatic model_step(input bit cv, input bit ff, input bit md);
        int chars_after;
        bool_room: begin end
        chars_after = (cv && m_chars < 2047) ? m_chars + 1 : m_chars;
        if (m_closing) begin
            if (!cv) begin
                m_closing = 0; m_in_flight = 1; m_chars = 0;
            end else begin
                m_chars = chars_after;
            end
        end else if (m_in_flight) begin
            m_chars = chars_after;
            if (md) begin
                m_in_flight = 0; m_building = (chars_after > 0); m_quiet = 0;
            end
        end else if (m_building) begin
            m_chars = chars_after;
            m_quiet = cv ? 0 : ((m_quiet < TO - 1) ? m_quiet + 1 : m_quiet);
            m_force = m_force | ff;
            if ((m_chars >= HW || m_quiet == TO - 1 || m_force) && enable && dma_armed
                && int'(output_fifo_counter) < DD - 1) begin
                m_building = 0; m_closing = 1; m_force = 0;
            end
        end else begin
            m_chars = chars_after;
            if (cv) begin
                m_building = 1; m_quiet = 0;
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, compare against the model, advance the model.
    task automatic tick(input bit cv, input bit ff, input bit md);
        @(negedge clk);
        char_valid = cv; force_flush = ff; marker_drained = md;
        enable = req_en; dma_armed = req_armed; output_fifo_counter = req_fifo;
        #1;
        check("m_strobe", {31'd0, receive_transfer_request}, {31'd0, (m_closing && !cv)});
        check("m_no_collide", {31'd0, receive_transfer_request & char_valid}, 32'd0);
        check("m_state", {30'd0, state_dbg}, model_state());
        check("m_count", {21'd0, unflushed_count}, m_chars);
        check("m_open", {31'd0, packet_open}, {31'd0, (m_chars != 0)});
        model_step(cv, ff, md);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        char_valid = 0; force_flush = 0; marker_drained = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        cv, ff, md;
        logic [1:0]  st;
        logic [10:0] cnt;
        logic        strobe;
    } vec_t;

    vec_t tbl[13];
    int   found;
    logic [31:0] snap_coll, snap_pkts;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 11'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd1, 11'd1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd1, 11'd2, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd1, 11'd3, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'd2, 11'd4, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd3, 11'd0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'd3, 11'd0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'd3, 11'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd3, 11'd2, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd1, 11'd2, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd2, 11'd2, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 2'd3, 11'd0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 11'd0, 1'b0};

        model_reset();
        #2 rst_n = 1'b0;
        #2;
        check("reset_strobe", {31'd0, receive_transfer_request}, 32'd0);
        check("reset_open", {31'd0, packet_open}, 32'd0);
        check("reset_count", {21'd0, unflushed_count}, 32'd0);
        check("reset_state", {30'd0, state_dbg}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // High-water flush, chars during drain, drain into ACCUM, force flush, drain into IDLE.
        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].cv, tbl[i].ff, tbl[i].md);
            check($sformatf("tbl%0d_state", i), {30'd0, state_dbg}, {30'd0, tbl[i].st});
            check($sformatf("tbl%0d_count", i), {21'd0, unflushed_count}, {21'd0, tbl[i].cnt});
            check($sformatf("tbl%0d_strobe", i), {31'd0, receive_transfer_request}, {31'd0, tbl[i].strobe});
        end

        // Collision: three chars while in REQUEST hold the strobe off.
`ifdef CONSOLE_FLUSH_STATS_EN
        snap_coll = collision_stalls; snap_pkts = packets_sent;
`endif
        repeat (4) tick(1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(1, 0, 0);
            check("coll_held", {31'd0, receive_transfer_request}, 32'd0);
            check("coll_state", {30'd0, state_dbg}, 32'd2);
        end
        tick(0, 0, 0);
        check("coll_strobe", {31'd0, receive_transfer_request}, 32'd1);
        check("coll_count", {21'd0, unflushed_count}, 32'd7);
`ifdef CONSOLE_FLUSH_STATS_EN
        @(posedge clk); #1;
        check("coll_stalls", collision_stalls - snap_coll, 32'd3);
        check("coll_pkts", packets_sent - snap_pkts, 32'd1);
`endif
        tick(0, 0, 1);
        tick(0, 0, 0);
        check("coll_idle", {30'd0, state_dbg}, 32'd0);

        // Idle timeout: strobe exactly TO cycles after a lone char.
        tick(1, 0, 0);
        found = -1;
        for (int k = 1; k <= 40; k++) begin
            tick(0, 0, 0);
            if (receive_transfer_request === 1'b1) begin
                found = k;
                break;
            end
        end
        check("timeout_latency", found, TO);
        tick(0, 0, 1);

        // dma_armed low stalls a due flush; raising it releases the strobe within two cycles.
        req_armed = 1'b0;
        repeat (4) tick(1, 0, 0);
        repeat (15) tick(0, 0, 0);
        check("armed_stall", {30'd0, state_dbg}, 32'd1);
        req_armed = 1'b1;
        found = -1;
        for (int k = 1; k <= 5; k++) begin
            tick(0, 0, 0);
            if (receive_transfer_request === 1'b1) begin found = k; break; end
        end
        check("armed_release", (found >= 1 && found <= 2), 32'd1);
        tick(0, 0, 1);

        // Full FIFO defers the flush until occupancy falls below DEPTH-1.
        req_fifo = 11'd999;
        repeat (4) tick(1, 0, 0);
        repeat (6) tick(0, 0, 0);
        check("fifo_stall", {30'd0, state_dbg}, 32'd1);
        req_fifo = 11'd998;
        found = -1;
        for (int k = 1; k <= 5; k++) begin
            tick(0, 0, 0);
            if (receive_transfer_request === 1'b1) begin found = k; break; end
        end
        check("fifo_release", (found >= 1 && found <= 2), 32'd1);
        req_fifo = 11'd0;
        tick(0, 0, 1);

        // Count saturation while flushing is blocked.
        req_en = 1'b0;
        repeat (2100) tick(1, 0, 0);
        tick(0, 0, 0);
        check("sat_count", {21'd0, unflushed_count}, 32'd2047);
        req_en = 1'b1;
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("sat_strobe", {31'd0, receive_transfer_request}, 32'd1);
        tick(0, 0, 1);

        // Force flush, then async reset in the middle of REQUEST.
        tick(1, 0, 0);
        tick(0, 1, 0);
        @(posedge clk); #2;
        check("force_req", {30'd0, state_dbg}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_strobe", {31'd0, receive_transfer_request}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        check("rst_count", {21'd0, unflushed_count}, 32'd0);
        check("rst_open", {31'd0, packet_open}, 32'd0);
        do_reset();
        tick(0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            tick(0, 0, 0);
            check("idle_force_ignored", {31'd0, receive_transfer_request}, 32'd0);
        end
        check("idle_force_state", {30'd0, state_dbg}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            req_en    = ($urandom % 10) != 0;
            req_armed = ($urandom % 8) != 0;
            req_fifo  = (($urandom % 6) == 0) ? 11'(998 + ($urandom % 2)) : 11'($urandom % 998);
            tick(($urandom % 3) == 0, ($urandom % 40) == 0, ($urandom % 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
